// File: rtl/memi_loader_if.sv
// Stream-in / MEMI-out bus bundle for the instruction line loader.
// master drives the request, stream beat and swap ack; slave is the loader.
interface memi_loader_if #(
  parameter int unsigned ADRS = 14,
  parameter int unsigned BITS = 128,
  parameter int unsigned INW  = 32
) ();
  logic              START;
  logic [ADRS-1:0]   LEN;
  logic [INW-1:0]    DIN;
  logic              DVALID;
  logic              DREADY;
  logic [ADRS-1:0]   WA;
  logic [2*BITS-1:0] DW;
  logic              WCEB;
  logic              BANK;
  logic              SWAP_REQ;
  logic              SWAP_ACK;
  logic              BUSY;
  logic              DONE;

  modport master (
    output START, LEN, DIN, DVALID, SWAP_ACK,
    input  DREADY, WA, DW, WCEB, BANK, SWAP_REQ, BUSY, DONE
  );

  modport slave (
    input  START, LEN, DIN, DVALID, SWAP_ACK,
    output DREADY, WA, DW, WCEB, BANK, SWAP_REQ, BUSY, DONE
  );
endinterface

// File: rtl/memi_loader.sv
// Assembles INW-bit stream beats into BITS-wide lines, writes them to the
// inactive MEMI bank, then handshakes a bank swap with the instruction reader.
module memi_loader #(
  parameter int unsigned ADRS = 14,
  parameter int unsigned BITS = 128,
  parameter int unsigned INW  = 32
) (
  input logic         CLK,
  input logic         RST,
  memi_loader_if.slave bus
);
  localparam int unsigned BEATS = BITS / INW;
  localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FILL      = 3'd1,
    WRITE     = 3'd2,
    WAIT_SWAP = 3'd3,
    FINISH    = 3'd4
  } state_t;

  state_t          state;
  logic [ADRS:0]   line_cnt;
  logic [ADRS-1:0] len_q;
  logic [BW-1:0]   beat_cnt;
  logic [BITS-1:0] line_buf;
  logic [BITS-1:0] line_nx;
  logic            last_beat;

  assign last_beat = (beat_cnt == BW'(BEATS - 1));

  // Partial line with the current beat merged into its lane.
  always_comb begin
    line_nx = line_buf;
    for (int unsigned i = 0; i < BEATS; i++) begin
      if (beat_cnt == BW'(i)) line_nx[i*INW +: INW] = bus.DIN;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= IDLE;
      line_cnt     <= '0;
      len_q        <= '0;
      beat_cnt     <= '0;
      line_buf     <= '0;
      bus.DREADY   <= 1'b0;
      bus.WA       <= '0;
      bus.DW       <= '0;
      bus.WCEB     <= 1'b1;
      bus.BANK     <= 1'b0;
      bus.SWAP_REQ <= 1'b0;
      bus.BUSY     <= 1'b0;
      bus.DONE     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.START && (bus.LEN != '0)) begin
            len_q      <= bus.LEN;
            line_cnt   <= '0;
            beat_cnt   <= '0;
            bus.DREADY <= 1'b1;
            bus.BUSY   <= 1'b1;
            state      <= FILL;
          end
        end
        FILL: begin
          if (bus.DVALID && bus.DREADY) begin
            line_buf <= line_nx;
            if (last_beat) begin
              bus.DREADY <= 1'b0;
              bus.WCEB   <= 1'b0;
              bus.WA     <= line_cnt[ADRS-1:0];
              bus.DW     <= {{BITS{1'b0}}, line_nx};
              state      <= WRITE;
            end else begin
              beat_cnt <= beat_cnt + BW'(1);
            end
          end
        end
        WRITE: begin
          bus.WCEB <= 1'b1;
          line_cnt <= line_cnt + 1'b1;
          if ((line_cnt + 1'b1) == {1'b0, len_q}) begin
            bus.SWAP_REQ <= 1'b1;
            state        <= WAIT_SWAP;
          end else begin
            beat_cnt   <= '0;
            bus.DREADY <= 1'b1;
            state      <= FILL;
          end
        end
        WAIT_SWAP: begin
          if (bus.SWAP_ACK) begin
            bus.BANK <= ~bus.BANK;
            bus.DONE <= 1'b1;
            state    <= FINISH;
          end
        end
        FINISH: begin
          bus.DONE     <= 1'b0;
          bus.SWAP_REQ <= 1'b0;
          bus.BUSY     <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_memi_loader.sv
// Directed bench for memi_loader: line assembly, write pulses, bank swap
// handshake, ignored requests and mid-load reset.
module tb_memi_loader;
  localparam int unsigned ADRS = 14;
  localparam int unsigned BITS = 128;
  localparam int unsigned INW  = 32;

  logic CLK = 1'b0;
  logic RST;
  int   tests = 0;
  int   fails = 0;

  logic [ADRS-1:0]   wa_q[$];
  logic [2*BITS-1:0] dw_q[$];

  memi_loader_if #(.ADRS(ADRS), .BITS(BITS), .INW(INW)) bus ();

  memi_loader #(.ADRS(ADRS), .BITS(BITS), .INW(INW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  // Record every write strobe mid-cycle.
  always @(negedge CLK) begin
    if (bus.WCEB === 1'b0) begin
      wa_q.push_back(bus.WA);
      dw_q.push_back(bus.DW);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chkv(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] mk_line(input logic [31:0] b0, input logic [31:0] b1,
                                           input logic [31:0] b2, input logic [31:0] b3);
    return {128'h0, b3, b2, b1, b0};
  endfunction

  task automatic check_write(input string tag, input int idx,
                             input logic [ADRS-1:0] exp_wa, input logic [255:0] exp_dw);
    if (idx < wa_q.size()) begin
      chkv({tag, "_wa"}, 256'(wa_q[idx]), 256'(exp_wa));
      chkv({tag, "_dw"}, dw_q[idx], exp_dw);
    end else begin
      chkv({tag, "_missing"}, 256'(wa_q.size()), 256'(idx + 1));
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    RST = 1'b0;
  endtask

  task automatic start_load(input logic [ADRS-1:0] len);
    bus.START = 1'b1;
    bus.LEN   = len;
    tick();
    bus.START = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d);
    int n = 0;
    bit took = 1'b0;
    bus.DVALID = 1'b1;
    bus.DIN    = d;
    while (!took && n < 50) begin
      took = (bus.DREADY === 1'b1);
      tick();
      n++;
    end
    if (!took) chk1("beat_accept_timeout", bus.DREADY, 1'b1);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (bus.DONE !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk1("done_seen", bus.DONE, 1'b1);
  endtask

  task automatic check_idle(input string tag);
    chk1({tag, "_dready"}, bus.DREADY, 1'b0);
    chk1({tag, "_wceb"}, bus.WCEB, 1'b1);
    chkv({tag, "_wa"}, 256'(bus.WA), 256'(0));
    chkv({tag, "_dw"}, bus.DW, 256'(0));
    chk1({tag, "_bank"}, bus.BANK, 1'b0);
    chk1({tag, "_swapreq"}, bus.SWAP_REQ, 1'b0);
    chk1({tag, "_busy"}, bus.BUSY, 1'b0);
    chk1({tag, "_done"}, bus.DONE, 1'b0);
  endtask

  initial begin
    logic [31:0] b[16];
    int n;

    RST          = 1'b1;
    bus.START    = 1'b0;
    bus.LEN      = '0;
    bus.DIN      = '0;
    bus.DVALID   = 1'b0;
    bus.SWAP_ACK = 1'b0;
    tick();
    tick();
    check_idle("reset");
    RST = 1'b0;

    // Two-line load, beats 0x11111111..0x88888888, immediate ack.
    wa_q.delete(); dw_q.delete();
    bus.SWAP_ACK = 1'b1;
    start_load(14'd2);
    for (int k = 1; k <= 8; k++) send_beat(32'(32'h11111111 * k));
    bus.DVALID = 1'b0;
    wait_done(30);
    chk1("t1_busy_in_finish", bus.BUSY, 1'b1);
    chk1("t1_bank", bus.BANK, 1'b1);
    tick();
    chk1("t1_done_cleared", bus.DONE, 1'b0);
    chk1("t1_busy_cleared", bus.BUSY, 1'b0);
    chk1("t1_swapreq_cleared", bus.SWAP_REQ, 1'b0);
    chkv("t1_nwrites", 256'(wa_q.size()), 256'(2));
    check_write("t1_w0", 0, 14'd0, {128'h0, 128'h44444444_33333333_22222222_11111111});
    check_write("t1_w1", 1, 14'd1, {128'h0, 128'h88888888_77777777_66666666_55555555});
    chk1("t1_wceb_hold", bus.WCEB, 1'b1);
    chkv("t1_wa_hold", 256'(bus.WA), 256'(1));

    // One-line load with ack withheld for 10 cycles.
    do_reset();
    wa_q.delete(); dw_q.delete();
    bus.SWAP_ACK = 1'b0;
    start_load(14'd1);
    for (int k = 0; k < 4; k++) send_beat(32'hA0000000 + 32'(k));
    bus.DVALID = 1'b0;
    n = 0;
    while (bus.WCEB !== 1'b0 && n < 20) begin tick(); n++; end
    chk1("t2_write_seen", bus.WCEB, 1'b0);
    tick();
    for (int i = 0; i < 10; i++) begin
      chk1("t2_swapreq_wait", bus.SWAP_REQ, 1'b1);
      chk1("t2_bank_wait", bus.BANK, 1'b0);
      chk1("t2_dready_wait", bus.DREADY, 1'b0);
      if (i == 9) bus.SWAP_ACK = 1'b1;
      tick();
    end
    chk1("t2_bank_toggled", bus.BANK, 1'b1);
    chk1("t2_done_pulse", bus.DONE, 1'b1);
    bus.SWAP_ACK = 1'b0;
    tick();
    chk1("t2_done_low", bus.DONE, 1'b0);
    chk1("t2_busy_low", bus.BUSY, 1'b0);
    chk1("t2_swapreq_low", bus.SWAP_REQ, 1'b0);
    check_write("t2_w0", 0, 14'd0, mk_line(32'hA0000000, 32'hA0000001, 32'hA0000002, 32'hA0000003));

    // Back-to-back loads; ack held high throughout including FILL.
    do_reset();
    wa_q.delete(); dw_q.delete();
    bus.SWAP_ACK = 1'b1;
    start_load(14'd1);
    chk1("t3_bank_fill", bus.BANK, 1'b0);
    for (int k = 0; k < 4; k++) send_beat(32'hB0000000 + 32'(k));
    bus.DVALID = 1'b0;
    wait_done(20);
    tick();
    chk1("t3_bank_first", bus.BANK, 1'b1);
    start_load(14'd1);
    for (int k = 0; k < 4; k++) send_beat(32'hC0000000 + 32'(k));
    bus.DVALID = 1'b0;
    wait_done(20);
    tick();
    chk1("t3_bank_second", bus.BANK, 1'b0);
    chkv("t3_nwrites", 256'(wa_q.size()), 256'(2));
    check_write("t3_w0", 0, 14'd0, mk_line(32'hB0000000, 32'hB0000001, 32'hB0000002, 32'hB0000003));
    check_write("t3_w1", 1, 14'd0, mk_line(32'hC0000000, 32'hC0000001, 32'hC0000002, 32'hC0000003));

    // START with LEN=0, then START pulsed during FILL.
    wa_q.delete(); dw_q.delete();
    bus.START = 1'b1;
    bus.LEN   = 14'd0;
    tick();
    bus.START = 1'b0;
    chk1("t4_len0_busy", bus.BUSY, 1'b0);
    chk1("t4_len0_dready", bus.DREADY, 1'b0);
    tick();
    chkv("t4_len0_nwrites", 256'(wa_q.size()), 256'(0));
    start_load(14'd1);
    send_beat(32'hD0000000);
    send_beat(32'hD0000001);
    bus.DVALID = 1'b0;
    bus.START  = 1'b1;
    bus.LEN    = 14'd3;
    tick();
    bus.START = 1'b0;
    chk1("t4_fill_busy", bus.BUSY, 1'b1);
    chk1("t4_fill_dready", bus.DREADY, 1'b1);
    chkv("t4_fill_nwrites", 256'(wa_q.size()), 256'(0));
    send_beat(32'hD0000002);
    send_beat(32'hD0000003);
    bus.DVALID = 1'b0;
    wait_done(20);
    tick(); tick(); tick();
    chkv("t4_nwrites", 256'(wa_q.size()), 256'(1));
    check_write("t4_w0", 0, 14'd0, mk_line(32'hD0000000, 32'hD0000001, 32'hD0000002, 32'hD0000003));

    // Reset after two beats of the third line.
    do_reset();
    wa_q.delete(); dw_q.delete();
    bus.SWAP_ACK = 1'b0;
    start_load(14'd4);
    for (int k = 0; k < 10; k++) send_beat(32'hE0000000 + 32'(k));
    bus.DVALID = 1'b0;
    RST = 1'b1;
    tick();
    check_idle("t5_reset");
    RST = 1'b0;
    bus.DVALID = 1'b1;
    tick(); tick(); tick();
    bus.DVALID = 1'b0;
    chkv("t5_nwrites", 256'(wa_q.size()), 256'(2));
    chk1("t5_bank", bus.BANK, 1'b0);
    chk1("t5_dready_idle", bus.DREADY, 1'b0);
    chk1("t5_busy_idle", bus.BUSY, 1'b0);

    // DVALID toggling every cycle, four lines.
    wa_q.delete(); dw_q.delete();
    bus.SWAP_ACK = 1'b1;
    start_load(14'd4);
    for (int k = 0; k < 16; k++) begin
      b[k] = 32'hF00D0000 + 32'(k * 3);
      send_beat(b[k]);
      bus.DVALID = 1'b0;
      tick();
    end
    wait_done(40);
    tick();
    chkv("t6_nwrites", 256'(wa_q.size()), 256'(4));
    for (int j = 0; j < 4; j++)
      check_write("t6_w", j, 14'(j), mk_line(b[4*j], b[4*j+1], b[4*j+2], b[4*j+3]));
    chk1("t6_bank", bus.BANK, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
